// File: rtl/array_2_2_feeder.sv
// array_2_2_feeder: weight loader and skewed vector feeder for a 2x2 array.
// A job loads weight column 2, then weight column 1, and streams vec_count
// vectors. Lane 1 gets each vector as it is accepted. Lane 2 gets it one
// cycle later. Three drain cycles then flush the skew before done.
// Optional feature macro: FEEDER_BIAS_EN.
//   Defined   -> col_1_initial/col_2_initial carry b1/b2 with the same skew.
//   Undefined -> b1/b2 are ignored and both column outputs stay 0.
module array_2_2_feeder (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] w11,
   input  logic [7:0] w12,
   input  logic [7:0] w21,
   input  logic [7:0] w22,
   input  logic [3:0] vec_count,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a1,
   input  logic [7:0] a2,
   input  logic [7:0] b1,
   input  logic [7:0] b2,
   output logic       load,
   output logic [7:0] row_1_load,
   output logic [7:0] row_2_load,
   output logic [7:0] row_1_data,
   output logic [7:0] row_2_data,
   output logic [7:0] col_1_initial,
   output logic [7:0] col_2_initial,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD2  = 3'd1,
      LOAD1  = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   state_t     state_reg;
   logic [7:0] w11_reg;
   logic [7:0] w21_reg;
   logic [3:0] vec_count_reg;
   logic [3:0] accept_cnt_reg;
   logic [1:0] drain_cnt_reg;
   logic       load_reg;
   logic [7:0] row_1_load_reg;
   logic [7:0] row_2_load_reg;
   logic [7:0] row_1_data_reg;
   logic [7:0] row_2_data_reg;
   logic [7:0] a2_pend_reg;
   logic       done_reg;
   logic       accept;

   // A vector can only be taken while streaming.
   assign in_ready = (state_reg == STREAM);
   assign accept   = in_valid & in_ready;
   assign busy     = (state_reg != IDLE);

   assign load       = load_reg;
   assign row_1_load = row_1_load_reg;
   assign row_2_load = row_2_load_reg;
   assign row_1_data = row_1_data_reg;
   assign row_2_data = row_2_data_reg;
   assign done       = done_reg;

   // Job sequencer with registered weight-load, data-lane and done outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         w11_reg        <= 8'd0;
         w21_reg        <= 8'd0;
         vec_count_reg  <= 4'd0;
         accept_cnt_reg <= 4'd0;
         drain_cnt_reg  <= 2'd0;
         load_reg       <= 1'b0;
         row_1_load_reg <= 8'd0;
         row_2_load_reg <= 8'd0;
         row_1_data_reg <= 8'd0;
         row_2_data_reg <= 8'd0;
         a2_pend_reg    <= 8'd0;
         done_reg       <= 1'b0;
      end else begin
         load_reg       <= 1'b0;
         row_1_load_reg <= 8'd0;
         row_2_load_reg <= 8'd0;
         done_reg       <= 1'b0;
         // Lane 1 shows the accepted a1 (or 0 on a bubble). Lane 2 replays
         // whatever lane 1's companion value was one cycle earlier.
         row_1_data_reg <= accept ? a1 : 8'd0;
         a2_pend_reg    <= accept ? a2 : 8'd0;
         row_2_data_reg <= a2_pend_reg;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  // Column 2 goes out first, so its weights bypass the latches.
                  w11_reg        <= w11;
                  w21_reg        <= w21;
                  vec_count_reg  <= vec_count;
                  accept_cnt_reg <= 4'd0;
                  load_reg       <= 1'b1;
                  row_1_load_reg <= w12;
                  row_2_load_reg <= w22;
                  state_reg      <= LOAD2;
               end
            end
            LOAD2: begin
               load_reg       <= 1'b1;
               row_1_load_reg <= w11_reg;
               row_2_load_reg <= w21_reg;
               state_reg      <= LOAD1;
            end
            LOAD1: begin
               drain_cnt_reg <= 2'd0;
               state_reg     <= (vec_count_reg == 4'd0) ? DRAIN : STREAM;
            end
            STREAM: begin
               if (accept) begin
                  accept_cnt_reg <= accept_cnt_reg + 4'd1;
                  if (accept_cnt_reg + 4'd1 == vec_count_reg) begin
                     drain_cnt_reg <= 2'd0;
                     state_reg     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               drain_cnt_reg <= drain_cnt_reg + 2'd1;
               // done is high during the third drain cycle.
               if (drain_cnt_reg == 2'd1) begin
                  done_reg <= 1'b1;
               end
               if (drain_cnt_reg == 2'd2) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef FEEDER_BIAS_EN
   logic [7:0] col_1_reg;
   logic [7:0] col_2_reg;
   logic [7:0] b2_pend_reg;

   assign col_1_initial = col_1_reg;
   assign col_2_initial = col_2_reg;

   // Bias lanes follow the same skew as the data lanes.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_1_reg   <= 8'd0;
         col_2_reg   <= 8'd0;
         b2_pend_reg <= 8'd0;
      end else begin
         col_1_reg   <= accept ? b1 : 8'd0;
         b2_pend_reg <= accept ? b2 : 8'd0;
         col_2_reg   <= b2_pend_reg;
      end
   end
`else
   logic unused_bias;

   // Without bias support the column inputs are dropped.
   assign unused_bias   = ^{b1, b2};
   assign col_1_initial = 8'd0;
   assign col_2_initial = 8'd0;
`endif

endmodule
